mem_sram_bridge: RTL and testbench

- Downstream stage of the prioritized memory arbiter. Consumes its single request stream and drives a fixed-latency synchronous SRAM port.
- Returns exactly one response per accepted request, strictly in order, into the arbiter's response channel.
- Buffers read data locally and uses a credit counter, so SRAM data is never dropped when the response consumer stalls.

---
 rtl/mem_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 67 ++++++
 rtl/mem_sram_bridge.sv | 99 +++++++++
 tb/tb_mem_sram_bridge.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Request/response types shared by the memory arbiter and the SRAM bridge.
// Bus widths are fixed here so both sides agree on the struct layout.
package mem_pkg;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int BE_WIDTH   = DATA_WIDTH / 8;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [BE_WIDTH-1:0]   be;
    logic                  we;
  } mem_req_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
  } mem_resp_t;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; DEPTH need not be a power of two.
// Head is read straight from the storage array, so a write never falls through.
module sync_fifo
  import mem_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);
  localparam int PTR_W = ptr_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  // Pop on an empty FIFO is ignored even if a push lands in the same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/mem_sram_bridge.sv
// Bridges the arbiter's request stream onto a fixed-latency SRAM port and returns
// one in-order response per request, with credits reserving response-buffer space.
module mem_sram_bridge
  import mem_pkg::*;
#(
  parameter int SRAM_LATENCY = 2,
  parameter int RESP_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  mem_req_t              req_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output mem_resp_t             resp_o,
  output logic                  sram_en_o,
  output logic                  sram_we_o,
  output logic [ADDR_WIDTH-1:0] sram_addr_o,
  output logic [DATA_WIDTH-1:0] sram_wdata_o,
  output logic [BE_WIDTH-1:0]   sram_be_o,
  input  logic [DATA_WIDTH-1:0] sram_rdata_i
);
  localparam int CNT_W = $clog2(RESP_DEPTH + 1);

  logic                    req_fire, resp_fire;
  logic [CNT_W-1:0]        outstanding_q, outstanding_d;
  logic [SRAM_LATENCY-1:0] pipe_vld_q, pipe_vld_d, pipe_we_q, pipe_we_d;
  logic                    fifo_push, fifo_full, fifo_empty;
  logic [DATA_WIDTH-1:0]   fifo_wdata, fifo_rdata;
  logic [CNT_W-1:0]        fifo_count;

  // Credits cover both in-flight accesses and buffered data, so a late SRAM
  // return always has a FIFO slot waiting for it.
  assign req_ready_o = !rst && (outstanding_q < CNT_W'(RESP_DEPTH));
  assign req_fire    = req_valid_i && req_ready_o;
  assign resp_fire   = resp_valid_o && resp_ready_i;

  assign sram_en_o    = req_fire;
  assign sram_we_o    = req_i.we;
  assign sram_addr_o  = req_i.addr;
  assign sram_wdata_o = req_i.wdata;
  assign sram_be_o    = req_i.be;

  assign pipe_vld_d[0] = req_fire;
  assign pipe_we_d[0]  = req_i.we;
  for (genvar gi = 1; gi < SRAM_LATENCY; gi++) begin : g_pipe
    assign pipe_vld_d[gi] = pipe_vld_q[gi-1];
    assign pipe_we_d[gi]  = pipe_we_q[gi-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld_q <= '0;
      pipe_we_q  <= '0;
    end else begin
      pipe_vld_q <= pipe_vld_d;
      pipe_we_q  <= pipe_we_d;
    end
  end

  // Writes still occupy a slot so the upstream tag queue stays aligned.
  assign fifo_push  = pipe_vld_q[SRAM_LATENCY-1];
  assign fifo_wdata = pipe_we_q[SRAM_LATENCY-1] ? '0 : sram_rdata_i;

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (resp_fire),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign resp_valid_o = !fifo_empty;
  assign resp_o.data  = fifo_rdata;

  always_comb begin
    outstanding_d = outstanding_q;
    if (req_fire && !resp_fire)      outstanding_d = outstanding_q + 1'b1;
    else if (!req_fire && resp_fire) outstanding_d = outstanding_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) outstanding_q <= '0;
    else     outstanding_q <= outstanding_d;
  end

  a_no_fifo_overflow : assert property (@(posedge clk) disable iff (rst)
    !(fifo_push && fifo_full));
  a_credit_bound : assert property (@(posedge clk) disable iff (rst)
    (outstanding_q <= CNT_W'(RESP_DEPTH)) && (fifo_count <= outstanding_q));
endmodule

// File: tb/tb_mem_sram_bridge.sv
// Randomized bench for mem_sram_bridge against a 2-cycle SRAM model and a
// transaction-level reference (expected-response queue with availability times).
module tb_mem_sram_bridge;
  import mem_pkg::*;

  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  typedef struct {
    logic [DATA_WIDTH-1:0] data;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  we;
    int                    avail;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  req_valid;
  logic                  req_ready;
  mem_req_t              req;
  logic                  resp_valid;
  logic                  resp_ready;
  mem_resp_t             resp;
  logic                  sram_en, sram_we;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic [DATA_WIDTH-1:0] sram_wdata, sram_rdata;
  logic [BE_WIDTH-1:0]   sram_be;

  always #5 clk = ~clk;

  mem_sram_bridge #(
    .SRAM_LATENCY (LAT),
    .RESP_DEPTH   (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_i        (req),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .resp_o       (resp),
    .sram_en_o    (sram_en),
    .sram_we_o    (sram_we),
    .sram_addr_o  (sram_addr),
    .sram_wdata_o (sram_wdata),
    .sram_be_o    (sram_be),
    .sram_rdata_i (sram_rdata)
  );

  function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] old_v,
                                                  input logic [DATA_WIDTH-1:0] wd,
                                                  input logic [BE_WIDTH-1:0] be);
    logic [DATA_WIDTH-1:0] r;
    r = old_v;
    for (int b = 0; b < BE_WIDTH; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  // SRAM model: read data appears LAT cycles after the enable cycle; no reset.
  logic [DATA_WIDTH-1:0] smem [256];
  logic [DATA_WIDTH-1:0] rd_p1, rd_p2;
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) smem[sram_addr[7:0]] <= merge(smem[sram_addr[7:0]], sram_wdata, sram_be);
      else         rd_p1 <= smem[sram_addr[7:0]];
    end
    rd_p2 <= rd_p1;
  end
  assign sram_rdata = rd_p2;

  // Reference state
  logic [DATA_WIDTH-1:0] rmem [256];
  exp_t     expq [$];
  mem_req_t pend [$];
  int       outst = 0;
  int       cyc = 0;
  int       n_checks = 0;
  int       n_errs = 0;
  int       n_resp = 0;
  int       dut_en_cnt = 0;
  logic     fire_g;
  logic     offer_en = 1'b1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic mem_req_t mk_rd(input logic [ADDR_WIDTH-1:0] a);
    mem_req_t r;
    r.addr = a; r.wdata = '0; r.be = '0; r.we = 1'b0;
    return r;
  endfunction

  function automatic mem_req_t mk_wr(input logic [ADDR_WIDTH-1:0] a,
                                     input logic [DATA_WIDTH-1:0] d,
                                     input logic [BE_WIDTH-1:0] be);
    mem_req_t r;
    r.addr = a; r.wdata = d; r.be = be; r.we = 1'b1;
    return r;
  endfunction

  // Evaluated mid-cycle: compare DUT outputs with the reference, then advance it.
  task automatic eval_cycle();
    logic exp_ready, exp_valid, rfire;
    exp_t e;
    fire_g = 1'b0;
    if (sram_en) dut_en_cnt++;
    if (rst) begin
      expq.delete();
      outst = 0;
      check_val("rst_req_ready", req_ready, 0);
      check_val("rst_resp_valid", resp_valid, 0);
      check_val("rst_sram_en", sram_en, 0);
      return;
    end
    exp_ready = (outst < DEPTH);
    exp_valid = (expq.size() > 0) && (expq[0].avail <= cyc);
    check_val("req_ready", req_ready, exp_ready);
    check_val("resp_valid", resp_valid, exp_valid);
    fire_g = req_valid && exp_ready;
    rfire  = resp_ready && exp_valid;
    check_val("sram_en", sram_en, fire_g);
    if (fire_g) begin
      check_val("sram_we", sram_we, req.we);
      check_val("sram_addr", sram_addr, req.addr);
      if (req.we) begin
        check_val("sram_wdata", sram_wdata, req.wdata);
        check_val("sram_be", sram_be, req.be);
      end
    end
    if (exp_valid) check_val("resp_data", resp.data, expq[0].data);
    if (rfire) begin
      e = expq.pop_front();
      outst--;
      n_resp++;
      $display("resp %0d: %s addr=%08h data=%08h cycle=%0d",
               n_resp, e.we ? "WR" : "RD", e.addr, resp.data, cyc);
    end
    if (fire_g) begin
      e.addr  = req.addr;
      e.we    = req.we;
      e.avail = cyc + LAT + 1;
      if (req.we) begin
        rmem[req.addr[7:0]] = merge(rmem[req.addr[7:0]], req.wdata, req.be);
        e.data = '0;
      end else begin
        e.data = rmem[req.addr[7:0]];
      end
      expq.push_back(e);
      outst++;
    end
  endtask

  task automatic tick();
    req_valid = offer_en && (pend.size() > 0);
    if (pend.size() > 0) req = pend[0];
    @(negedge clk);
    eval_cycle();
    if (fire_g) void'(pend.pop_front());
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    int base;
    logic [DATA_WIDTH-1:0] v;
    req_valid  = 1'b0;
    req        = mk_rd('0);
    resp_ready = 1'b0;
    for (int i = 0; i < 256; i++) begin
      v = $urandom;
      smem[i] = v;
      rmem[i] = v;
    end
    smem[8'h10] = 32'hDEADBEEF;
    rmem[8'h10] = 32'hDEADBEEF;

    // Reset held, then released
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Single read, then write with partial byte enables followed by read-back
    resp_ready = 1'b1;
    pend.push_back(mk_rd(32'h10));
    repeat (6) tick();
    pend.push_back(mk_wr(32'h20, 32'h12345678, 4'b0011));
    pend.push_back(mk_rd(32'h20));
    repeat (8) tick();

    // Back-to-back reads at full throughput
    for (int i = 0; i < 8; i++) pend.push_back(mk_rd(32'(i * 4)));
    repeat (14) tick();

    // Consumer stalled: only DEPTH requests may be accepted
    resp_ready = 1'b0;
    base = dut_en_cnt;
    for (int i = 0; i < 6; i++) pend.push_back(mk_rd(32'(8'h40 + i * 4)));
    repeat (8) tick();
    check_val("stall_accepts", dut_en_cnt - base, DEPTH);
    resp_ready = 1'b1;
    repeat (14) tick();

    // Simultaneous accept and pop at three outstanding
    resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) pend.push_back(mk_rd(32'(i * 4)));
    repeat (5) tick();
    pend.push_back(mk_rd(32'h10));
    resp_ready = 1'b1;
    repeat (10) tick();

    // Reset pulse with reads in flight and buffered
    resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) pend.push_back(mk_rd(32'(8'h30 + i * 4)));
    repeat (4) tick();
    #2;
    rst = 1'b1;
    #1;
    check_val("async_rst_resp_valid", resp_valid, 0);
    check_val("async_rst_req_ready", req_ready, 0);
    tick();
    rst = 1'b0;
    pend.delete();
    resp_ready = 1'b1;
    repeat (5) tick();
    pend.push_back(mk_rd(32'h10));
    repeat (6) tick();

    // Random traffic with random backpressure
    for (int c = 0; c < 400; c++) begin
      if (pend.size() < 2) begin
        if ($urandom_range(0, 1) == 1)
          pend.push_back(mk_wr(32'($urandom_range(0, 15) * 4), $urandom, 4'($urandom_range(0, 15))));
        else
          pend.push_back(mk_rd(32'($urandom_range(0, 15) * 4)));
      end
      offer_en   = ($urandom_range(0, 3) != 0);
      resp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    offer_en   = 1'b1;
    resp_ready = 1'b1;
    for (int c = 0; c < 60 && (pend.size() > 0 || expq.size() > 0); c++) tick();
    check_val("drain_pending", pend.size(), 0);
    check_val("drain_responses", expq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule
